// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: FSM states, parity codes, legal widths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit hold counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last cycle of a bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic bit_done
);

  logic [CNT_W-1:0] cnt_q;

  assign bit_done = !clear && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (clear || bit_done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stops.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN (adds BREAK_REQ).
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK_REQ,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_tx_framer: DATA_WIDTH out of range");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_framer: CLKS_PER_BIT must be >= 1");
  end

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  brk_req;
  logic                  bit_done;
  logic                  timer_clear;

`ifdef UART_TX_BREAK_EN
  assign brk_req = BREAK_REQ;
`else
  assign brk_req = 1'b0;
`endif

  // The counter only runs in timed bit states; IDLE and BREAK have no fixed length.
  assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_BREAK);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (timer_clear),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (brk_req) begin
          state_d = ST_BREAK;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          stop2_d = 1'b0;
        end else if (DATA_VALID) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          shreg_d   = TX_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^TX_DATA) ^ (PAR_TYP == PAR_ODD);
          stop2_d   = STOP2;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        // idx counts stop periods already sent when two are owed
        if (bit_done) begin
          if (stop2_q && idx_q == '0) begin
            idx_d = IDX_W'(1);
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            idx_d   = '0;
          end
        end
      end
      ST_BREAK: begin
        if (!brk_req) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule
